// File: rtl/alu.sv
// Registered integer ALU for the execute stage: MIPS-style primary opcode
// applied to two operands, result and {N,Z,C,V} captured on each rising edge.
module alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Value1,
    input  logic [WIDTH-1:0] Value2,
    input  logic [5:0]       OPCode,
    output logic [3:0]       ResultC,
    output logic [WIDTH-1:0] Status
);

    typedef enum logic [5:0] {
        OP_BEQ  = 6'b000100,
        OP_BNE  = 6'b000101,
        OP_ADD  = 6'b001000,
        OP_ADDU = 6'b001001,
        OP_SLT  = 6'b001010,
        OP_SLTU = 6'b001011,
        OP_AND  = 6'b001100,
        OP_OR   = 6'b001101,
        OP_XOR  = 6'b001110,
        OP_LUI  = 6'b001111,
        OP_SUB  = 6'b100010,
        OP_SUBU = 6'b100011
    } opcode_e;

    opcode_e          op;
    logic [WIDTH-1:0] b_inv;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             add_v;
    logic             sub_v;
    logic             lt_s;
    logic             lt_u;

    logic [WIDTH-1:0] status_d, status_q;
    logic [3:0]       flags_d, flags_q;
    logic             carry_d;
    logic             ovf_d;
    logic             valid_d;

    assign op = opcode_e'(OPCode);

    // Subtraction shares the adder form A + ~B + 1 so carry means "no borrow".
    always_comb begin
        b_inv    = ~Value2;
        add_full = {1'b0, Value1} + {1'b0, Value2};
        sub_full = {1'b0, Value1} + {1'b0, b_inv} + {{WIDTH{1'b0}}, 1'b1};
        add_v    = (Value1[WIDTH-1] == Value2[WIDTH-1]) &&
                   (add_full[WIDTH-1] != Value1[WIDTH-1]);
        sub_v    = (Value1[WIDTH-1] == b_inv[WIDTH-1]) &&
                   (sub_full[WIDTH-1] != Value1[WIDTH-1]);
        lt_s     = $signed(Value1) < $signed(Value2);
        lt_u     = Value1 < Value2;
    end

    always_comb begin
        status_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        valid_d  = 1'b1;
        unique case (op)
            OP_ADD: begin
                status_d = add_full[WIDTH-1:0];
                carry_d  = add_full[WIDTH];
                ovf_d    = add_v;
            end
            OP_ADDU: begin
                status_d = add_full[WIDTH-1:0];
                carry_d  = add_full[WIDTH];
            end
            OP_SUB: begin
                status_d = sub_full[WIDTH-1:0];
                carry_d  = sub_full[WIDTH];
                ovf_d    = sub_v;
            end
            OP_SUBU: begin
                status_d = sub_full[WIDTH-1:0];
                carry_d  = sub_full[WIDTH];
            end
            OP_SLT:  status_d = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: status_d = {{(WIDTH-1){1'b0}}, lt_u};
            OP_AND:  status_d = Value1 & Value2;
            OP_OR:   status_d = Value1 | Value2;
            OP_XOR:  status_d = Value1 ^ Value2;
            OP_LUI:  status_d = {Value2[15:0], {(WIDTH-16){1'b0}}};
            OP_BEQ:  status_d = {{(WIDTH-1){1'b0}}, (Value1 == Value2)};
            OP_BNE:  status_d = {{(WIDTH-1){1'b0}}, (Value1 != Value2)};
            default: valid_d  = 1'b0;
        endcase
        // Unrecognised opcodes report an all-clear code, not Z=1.
        flags_d = valid_d ? {status_d[WIDTH-1], (status_d == '0), carry_d, ovf_d}
                          : 4'b0000;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            status_q <= '0;
            flags_q  <= '0;
        end else begin
            status_q <= status_d;
            flags_q  <= flags_d;
        end
    end

    assign Status  = status_q;
    assign ResultC = flags_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases followed by randomized
// operations compared against an arithmetic reference model.
module tb_alu;

    logic        Clock;
    logic        Reset_n;
    logic [31:0] Value1;
    logic [31:0] Value2;
    logic [5:0]  OPCode;
    logic [3:0]  ResultC;
    logic [31:0] Status;

    int unsigned checks;
    int unsigned errors;

    localparam logic [5:0] ADD  = 6'b001000, ADDU = 6'b001001,
                           SUB  = 6'b100010, SUBU = 6'b100011,
                           SLT  = 6'b001010, SLTU = 6'b001011,
                           AND_ = 6'b001100, OR_  = 6'b001101,
                           XOR_ = 6'b001110, LUI  = 6'b001111,
                           BEQ  = 6'b000100, BNE  = 6'b000101,
                           NOP  = 6'b111111;

    alu #(.WIDTH(32)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Value1  (Value1),
        .Value2  (Value2),
        .OPCode  (OPCode),
        .ResultC (ResultC),
        .Status  (Status)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: 64-bit integer arithmetic, flags from range checks.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [5:0] op,
                                  output logic [31:0] s, output logic [3:0] f);
        longint ua, ub, sa, sb, us, ss;
        logic c, v, ok;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0; v = 1'b0; ok = 1'b1; s = 32'd0;
        case (op)
            ADD, ADDU: begin
                us = ua + ub;
                ss = sa + sb;
                s  = us[31:0];
                c  = us > 64'sd4294967295;
                v  = (op == ADD) && (ss > 64'sd2147483647 || ss < -64'sd2147483648);
            end
            SUB, SUBU: begin
                ss = sa - sb;
                s  = a - b;
                c  = ua >= ub;
                v  = (op == SUB) && (ss > 64'sd2147483647 || ss < -64'sd2147483648);
            end
            SLT:  s = (sa < sb) ? 32'd1 : 32'd0;
            SLTU: s = (ua < ub) ? 32'd1 : 32'd0;
            AND_: s = a & b;
            OR_:  s = a | b;
            XOR_: s = a ^ b;
            LUI:  s = b << 16;
            BEQ:  s = (a == b) ? 32'd1 : 32'd0;
            BNE:  s = (a != b) ? 32'd1 : 32'd0;
            default: ok = 1'b0;
        endcase
        f = ok ? {s[31], (s == 32'd0), c, v} : 4'b0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] exp_s,
                         input logic [3:0] exp_f);
        checks++;
        assert (Status === exp_s && ResultC === exp_f) else begin
            errors++;
            $error("FAIL %s: Status=%h ResultC=%b expected Status=%h ResultC=%b",
                   tag, Status, ResultC, exp_s, exp_f);
        end
    endtask

    // Drive on falling edge, sample 1 time unit after the capturing edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] op, input string tag);
        logic [31:0] es;
        logic [3:0]  ef;
        @(negedge Clock);
        Value1 = a; Value2 = b; OPCode = op;
        model(a, b, op, es, ef);
        @(posedge Clock);
        #1;
        check(tag, es, ef);
    endtask

    task automatic step_exp(input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] op, input string tag,
                            input logic [31:0] es, input logic [3:0] ef);
        @(negedge Clock);
        Value1 = a; Value2 = b; OPCode = op;
        @(posedge Clock);
        #1;
        check(tag, es, ef);
    endtask

    logic [5:0]  ops [12];
    logic [31:0] ra, rb;
    logic [5:0]  rop;

    initial begin
        checks = 0;
        errors = 0;
        ops = '{ADD, ADDU, SUB, SUBU, SLT, SLTU, AND_, OR_, XOR_, LUI, BEQ, BNE};

        Reset_n = 1'b0;
        Value1 = 32'd5; Value2 = 32'd0; OPCode = ADD;
        #2;
        check("reset_async", 32'd0, 4'd0);
        repeat (2) @(posedge Clock);
        #1;
        check("reset_held", 32'd0, 4'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        check("first_capture", 32'd5, 4'b0000);

        step_exp(32'd0, 32'd5, ADD, "add_basic", 32'h5, 4'b0000);
        for (int i = 1; i <= 5; i++)
            step_exp(32'd10 * i, 32'd5 + 32'd20 * i, ADD, "add_track",
                     32'd5 + 32'd30 * i, 4'b0000);
        step_exp(32'hFFFFFFFB, 32'hFFFFFFF9, ADD, "add_neg_carry", 32'hFFFFFFF4, 4'b1010);
        step_exp(32'h7FFFFFFF, 32'd1, ADD,  "add_ovf",  32'h80000000, 4'b1001);
        step_exp(32'h7FFFFFFF, 32'd1, ADDU, "addu_ovf", 32'h80000000, 4'b1000);
        step_exp(32'hFFFFFFFB, 32'd5, SLT,  "slt",  32'd1, 4'b0000);
        step_exp(32'hFFFFFFFB, 32'd5, SLTU, "sltu", 32'd0, 4'b0100);
        step_exp(32'd5, 32'd5, BEQ, "beq", 32'd1, 4'b0000);
        step_exp(32'd5, 32'd5, BNE, "bne", 32'd0, 4'b0100);
        step_exp(32'd5, 32'd5, NOP, "nop", 32'd0, 4'b0000);
        step_exp(32'd5, 32'd5, SUB, "sub_zero", 32'd0, 4'b0110);
        step_exp(32'd0, 32'd1, SUB, "sub_borrow", 32'hFFFFFFFF, 4'b1000);
        step_exp(32'h80000000, 32'd1, SUB,  "sub_ovf",  32'h7FFFFFFF, 4'b0011);
        step_exp(32'h80000000, 32'd1, SUBU, "subu_ovf", 32'h7FFFFFFF, 4'b0010);
        step_exp(32'h0, 32'h1234ABCD, LUI, "lui", 32'hABCD0000, 4'b1000);

        // Inputs changing between edges must not disturb held outputs.
        step_exp(32'd3, 32'd4, ADD, "hold_setup", 32'd7, 4'b0000);
        @(negedge Clock);
        Value1 = 32'hFFFFFFFF; Value2 = 32'hFFFFFFFF; OPCode = XOR_;
        #2;
        check("hold_between_edges", 32'd7, 4'b0000);

        // Asynchronous reset between edges clears outputs immediately.
        @(posedge Clock);
        #1;
        check("xor_all_ones", 32'd0, 4'b0100);
        @(negedge Clock);
        Value1 = 32'd9; Value2 = 32'd9; OPCode = ADD;
        #1;
        Reset_n = 1'b0;
        #1;
        check("reset_midop", 32'd0, 4'd0);
        @(posedge Clock);
        #1;
        check("reset_midop_held", 32'd0, 4'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        check("after_reset", 32'd18, 4'b0000);

        step(32'd0, 32'hFFFFFFFF, ADD, "add_edge0");
        step(32'hFFFFFFFF, 32'hFFFFFFFF, SUB, "sub_ones");
        step(32'h80000000, 32'h80000000, ADD, "add_minmin");

        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            if ($urandom_range(0, 9) == 0) rop = 6'($urandom);
            else rop = ops[$urandom_range(0, 11)];
            step(ra, rb, rop, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
